booth_product_accumulator: RTL and testbench

- Downstream stage of the radix-4 Booth multiplier inside each systolic processing element.
- Receives per-operand tags (valid/first/last) issued alongside multiplier operands and delays them by the multiplier latency so they align with the product.
- Accumulates a dot-product run of signed products with saturation.
- Buffers finished sums in a small output FIFO with a valid/ready handshake toward the array drain logic.
- Issues credit-based in_ready, because the multiplier pipeline has no stall.

---
 rtl/booth_product_accumulator_pkg.sv | 19 +
 rtl/booth_product_accumulator_if.sv | 26 ++
 rtl/booth_product_accumulator_fifo.sv | 40 ++++
 rtl/booth_product_accumulator.sv | 109 ++++++++++
 tb/tb_booth_product_accumulator.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_product_accumulator_pkg.sv
// Shared types for the Booth product accumulator: operand tag and run FSM states.
package booth_product_accumulator_pkg;

    // Tag issued alongside each multiplier operand pair
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Run FSM: IDLE = no run open, ACCUM = a run is accumulating
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } run_state_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, first: 1'b0, last: 1'b0};

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Issue/product/result bus between the PE multiplier, accumulator and drain logic.
interface booth_product_accumulator_if #(
    parameter int N     = 8,
    parameter int ACC_W = 24
);
    logic               tag_valid;
    logic               tag_first;
    logic               tag_last;
    logic               in_ready;
    logic [2*N-1:0]     prod_in;
    logic [ACC_W-1:0]   acc_out;
    logic               ovf_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output tag_valid, tag_first, tag_last, prod_in, out_ready,
        input  in_ready, acc_out, ovf_out, out_valid, busy
    );

    modport slave (
        input  tag_valid, tag_first, tag_last, prod_in, out_ready,
        output in_ready, acc_out, ovf_out, out_valid, busy
    );
endinterface

// File: rtl/booth_product_accumulator_fifo.sv
// Result FIFO: DEPTH entries, no bypass (a push into an empty FIFO shows next cycle).
module acc_result_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage array; contents are only meaningful under count_q
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/booth_product_accumulator.sv
// Aligns operand tags with Booth products, accumulates saturating dot-product
// runs and queues finished sums behind a credit-based issue handshake.
module booth_product_accumulator
    import booth_product_accumulator_pkg::*;
#(
    parameter int N       = 8,
    parameter int ACC_W   = 24,
    parameter int MUL_LAT = 3,
    parameter int DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    booth_product_accumulator_if.slave bus
);
    localparam int PW = 2 * N;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(DEPTH + MUL_LAT + 1) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    tag_t          pipe_q [1:MUL_LAT];
    tag_t          d;
    run_state_t    state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [ACC_W-1:0] base, ext, sum_raw, sum_sat;
    logic          first_eff, ovf_now, ovf_next;
    logic          push, pop, any_tag;
    logic [SW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [ACC_W:0] fifo_head;

    assign d = pipe_q[MUL_LAT];

    // Tag delay line matching the multiplier latency; flushed by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= MUL_LAT; i++) pipe_q[i] <= TAG_NONE;
        end else begin
            pipe_q[1] <= '{valid: bus.tag_valid, first: bus.tag_first, last: bus.tag_last};
            for (int i = 2; i <= MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Saturating accumulate; a product arriving in IDLE starts a run implicitly
    always_comb begin
        first_eff = d.first | (state_q == IDLE);
        base      = first_eff ? '0 : acc_q;
        ext       = {{(ACC_W-PW){bus.prod_in[PW-1]}}, bus.prod_in};
        sum_raw   = base + ext;
        ovf_now   = (base[ACC_W-1] == ext[ACC_W-1]) && (sum_raw[ACC_W-1] != base[ACC_W-1]);
        sum_sat   = ovf_now ? (base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
        ovf_next  = (ovf_q & ~first_eff) | ovf_now;
    end

    // Run FSM next state and accumulator update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (d.valid) begin
            state_d = d.last ? IDLE : ACCUM;
            acc_d   = sum_sat;
            ovf_d   = ovf_next;
        end
    end

    // Run state, accumulator and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign push = d.valid & d.last;
    assign pop  = bus.out_valid & bus.out_ready;

    acc_result_fifo #(.W(ACC_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({ovf_next, sum_sat}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Credits reserved by every last-tag still in the pipe (including this cycle's push)
    always_comb begin
        inflight = '0;
        any_tag  = 1'b0;
        for (int i = 1; i <= MUL_LAT; i++) begin
            inflight = inflight + {{(SW-1){1'b0}}, pipe_q[i].valid & pipe_q[i].last};
            any_tag  = any_tag | pipe_q[i].valid;
        end
    end

    assign bus.in_ready  = (SW'(fifo_count) + inflight) < SW'(DEPTH);
    assign bus.out_valid = (fifo_count != '0);
    assign bus.acc_out   = bus.out_valid ? fifo_head[ACC_W-1:0] : '0;
    assign bus.ovf_out   = bus.out_valid & fifo_head[ACC_W];
    assign bus.busy      = any_tag | (state_q == ACCUM) | bus.out_valid;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench: a behavioural multiplier pipe feeds prod_in, a saturating
// model predicts each finished run, and results are compared as they drain.
module tb_booth_product_accumulator;
    localparam int N       = 8;
    localparam int ACC_W   = 17;
    localparam int MUL_LAT = 3;
    localparam int DEPTH   = 4;
    localparam int MAXV    = 65535;
    localparam int MINV    = -65536;

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_product_accumulator_if #(.N(N), .ACC_W(ACC_W)) bus ();

    booth_product_accumulator #(.N(N), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   mp[MUL_LAT];
    int   m_acc  = 0;
    bit   m_ovf  = 0;
    bit   m_open = 0;

    // Reference model of one issued operand pair
    task automatic model_issue(input int p, input bit f, input bit l);
        longint s;
        bit fe;
        fe = f || !m_open;
        if (fe) m_ovf = 0;
        s = (fe ? 0 : m_acc) + p;
        if (s > MAXV) begin s = MAXV; m_ovf = 1; end
        else if (s < MINV) begin s = MINV; m_ovf = 1; end
        m_acc  = int'(s);
        m_open = !l;
        if (l) sbq.push_back('{acc: int'(s), ovf: m_ovf});
    endtask

    // One clock: drive inputs, score any pop, advance the multiplier pipe
    task automatic cycle(input bit v, input bit f, input bit l, input int p, input bit ordy);
        exp_t e;
        bus.tag_valid = v;
        bus.tag_first = f;
        bus.tag_last  = l;
        bus.out_ready = ordy;
        if (v) model_issue(p, f, l);
        #3;
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: acc_out=%0d with no result expected", $signed(bus.acc_out));
            end else begin
                e = sbq.pop_front();
                if ($signed(bus.acc_out) !== e.acc || bus.ovf_out !== e.ovf) begin
                    failures++;
                    $display("FAIL sb_result: got acc=%0d ovf=%0b, want acc=%0d ovf=%0b",
                             $signed(bus.acc_out), bus.ovf_out, e.acc, e.ovf);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = MUL_LAT - 1; k > 0; k--) mp[k] = mp[k-1];
        mp[0] = v ? p : 0;
        bus.prod_in = 16'(mp[MUL_LAT-1]);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, ordy);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1, 1);
        idle(2, 1);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d results still pending, want 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        bus.tag_valid = 0; bus.tag_first = 0; bus.tag_last = 0;
        bus.prod_in = '0; bus.out_ready = 0;
        rst = 1;
        #12;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.ovf_out, bus.busy} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: ready/valid/ovf/busy=%b, want 1000",
                     {bus.in_ready, bus.out_valid, bus.ovf_out, bus.busy});
        end
        checks++;
        if (bus.acc_out !== '0) begin
            failures++;
            $display("FAIL reset_acc: acc_out=%0d, want 0", $signed(bus.acc_out));
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_run3();
        cycle(1, 1, 0, 100, 1);
        cycle(1, 0, 0, -30, 1);
        cycle(1, 0, 1, 7, 1);
        idle(2, 1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL run3_early: out_valid=%b before product push, want 0", bus.out_valid);
        end
        idle(1, 1);
        checks++;
        if (bus.out_valid !== 1'b1 || $signed(bus.acc_out) !== 77) begin
            failures++;
            $display("FAIL run3_latency: out_valid=%b acc_out=%0d, want 1 and 77",
                     bus.out_valid, $signed(bus.acc_out));
        end
        drain("run3");
    endtask

    task automatic test_saturation();
        // 5*16129 exceeds 65535 and clamps; the next run starts clean
        for (int i = 0; i < 5; i++) cycle(1, i == 0, i == 4, 16129, 1);
        cycle(1, 1, 1, -16256, 1);
        drain("saturation");
    endtask

    task automatic test_restart();
        cycle(1, 1, 0, 5, 1);
        cycle(1, 1, 1, 9, 1);
        drain("restart");
    endtask

    task automatic test_implicit_first();
        cycle(1, 0, 0, 4, 1);
        cycle(1, 0, 1, 6, 1);
        drain("implicit_first");
    endtask

    task automatic test_backpressure();
        int waited;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_ready_before: issue %0d in_ready=%b, want 1", i, bus.in_ready);
            end
            cycle(1, 1, 1, 10 * i + 1, 0);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_drop: in_ready=%b after 4 issues, want 0", bus.in_ready);
        end
        idle(6, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || $signed(bus.acc_out) !== 1) begin
            failures++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b head=%0d, want 1 0 1",
                     bus.out_valid, bus.in_ready, $signed(bus.acc_out));
        end
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 10) begin
            idle(1, 1);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_back: in_ready=%b after %0d pops, want 1", bus.in_ready, waited);
        end
        cycle(1, 1, 1, 41, 1);
        cycle(1, 1, 1, -51, 1);
        drain("backpressure");
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: out_valid=%b after drain, want 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        bit stray;
        cycle(1, 1, 1, 11, 0);
        idle(4, 0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_setup: out_valid=%b, want 1", bus.out_valid);
        end
        cycle(1, 1, 0, 3, 0);
        cycle(1, 0, 0, 4, 0);
        bus.tag_valid = 0;
        #3;
        rst = 1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.ovf_out, bus.busy} !== 4'b1000 || bus.acc_out !== '0) begin
            failures++;
            $display("FAIL ar_outputs: ready/valid/ovf/busy=%b acc=%0d, want 1000 and 0",
                     {bus.in_ready, bus.out_valid, bus.ovf_out, bus.busy}, $signed(bus.acc_out));
        end
        sbq.delete();
        m_open = 0;
        @(posedge clk); #1;
        rst = 0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1, 1);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) stray = 1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL ar_after: late products pushed or busy/in_ready wrong (valid=%b busy=%b ready=%b), want 0 0 1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    initial begin
        for (int k = 0; k < MUL_LAT; k++) mp[k] = 0;
        test_reset();
        test_run3();
        test_saturation();
        test_restart();
        test_implicit_first();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
